// File: rtl/eth_vlg_rx_fcs_strip.sv
// Receive framing stage: strips preamble/SFD, checks CRC-32 and length,
// removes the FCS and forwards payload bytes with sof/eof/err markers.
module eth_vlg_rx_fcs_strip #(
    parameter int PRE_MIN = 5,
    parameter int PRE_MAX = 15,
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk_rx,
    input  logic        rst_rx_n,
    input  logic        in_val,
    input  logic [7:0]  in_dat,
    output logic [7:0]  out_dat,
    output logic        out_val,
    output logic        out_sof,
    output logic        out_eof,
    output logic        out_err,
    output logic [15:0] frames_ok,
    output logic [15:0] frames_bad
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [7:0]  SFD_BYTE    = 8'hD5;
    localparam logic [7:0]  PRE_MIN_C   = 8'(PRE_MIN);
    localparam logic [7:0]  PRE_MAX_C   = 8'(PRE_MAX);
    localparam logic [15:0] MIN_LEN_C   = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_C   = 16'(MAX_LEN);
    localparam logic [15:0] LEN_SAT     = 16'hFFFF;
    localparam logic [15:0] FCS_HOLD    = 16'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } state_t;

    // Reflected CRC-32 update, one byte, LSB first
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] dat);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ dat[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    state_t           state_r, state_s;
    logic [7:0]       pre_cnt_r, pre_cnt_s;
    logic [15:0]      len_r, len_s;
    logic [31:0]      crc_r, crc_s;
    logic [4:0][7:0]  sreg_r, sreg_s;
    logic [7:0]       dat_s;
    logic             val_s, sof_s, eof_s, err_s;
    logic             ok_inc_s, bad_inc_s;

    // Next-state, datapath and output decode
    always_comb begin
        state_s   = state_r;
        pre_cnt_s = pre_cnt_r;
        len_s     = len_r;
        crc_s     = crc_r;
        sreg_s    = sreg_r;
        dat_s     = 8'h00;
        val_s     = 1'b0;
        sof_s     = 1'b0;
        eof_s     = 1'b0;
        err_s     = 1'b0;
        ok_inc_s  = 1'b0;
        bad_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_val) begin
                    if (in_dat == PRE_BYTE) begin
                        state_s   = ST_PRE;
                        pre_cnt_s = 8'd1;
                    end else begin
                        state_s = ST_DROP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PRE: begin
                if (!in_val) begin
                    state_s   = ST_IDLE;
                    bad_inc_s = 1'b1;
                end else if (in_dat == PRE_BYTE) begin
                    if (pre_cnt_r >= PRE_MAX_C) begin
                        state_s = ST_DROP;
                    end else begin
                        pre_cnt_s = pre_cnt_r + 8'd1;
                    end
                end else if (in_dat == SFD_BYTE) begin
                    if (pre_cnt_r >= PRE_MIN_C) begin
                        state_s = ST_DATA;
                        crc_s   = CRC_INIT;
                        len_s   = 16'd0;
                        sreg_s  = '0;
                    end else begin
                        state_s = ST_DROP;
                    end
                end else begin
                    state_s = ST_DROP;
                end
            end
            ST_DATA: begin
                // The newest four bytes are held back: they may turn out to be the FCS
                if (in_val) begin
                    crc_s  = crc32_byte(crc_r, in_dat);
                    sreg_s = {sreg_r[3:0], in_dat};
                    if (len_r != LEN_SAT) begin
                        len_s = len_r + 16'd1;
                    end else begin
                        len_s = len_r;
                    end
                    if (len_r >= FCS_HOLD) begin
                        val_s = 1'b1;
                        dat_s = sreg_r[4];
                        sof_s = (len_r == FCS_HOLD);
                    end else begin
                        val_s = 1'b0;
                    end
                end else begin
                    state_s = ST_IDLE;
                    if (len_r >= FCS_HOLD) begin
                        val_s     = 1'b1;
                        eof_s     = 1'b1;
                        dat_s     = sreg_r[4];
                        sof_s     = (len_r == FCS_HOLD);
                        err_s     = (crc_r != CRC_RESIDUE) || (len_r < MIN_LEN_C) || (len_r > MAX_LEN_C);
                        ok_inc_s  = ~err_s;
                        bad_inc_s = err_s;
                    end else begin
                        bad_inc_s = 1'b1;
                    end
                end
            end
            ST_DROP: begin
                if (!in_val) begin
                    state_s   = ST_IDLE;
                    bad_inc_s = 1'b1;
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk_rx or negedge rst_rx_n) begin
        if (!rst_rx_n) begin
            state_r    <= ST_IDLE;
            pre_cnt_r  <= 8'd0;
            len_r      <= 16'd0;
            crc_r      <= 32'd0;
            sreg_r     <= '0;
            out_dat    <= 8'h00;
            out_val    <= 1'b0;
            out_sof    <= 1'b0;
            out_eof    <= 1'b0;
            out_err    <= 1'b0;
            frames_ok  <= 16'd0;
            frames_bad <= 16'd0;
        end else begin
            state_r   <= state_s;
            pre_cnt_r <= pre_cnt_s;
            len_r     <= len_s;
            crc_r     <= crc_s;
            sreg_r    <= sreg_s;
            out_dat   <= dat_s;
            out_val   <= val_s;
            out_sof   <= sof_s;
            out_eof   <= eof_s;
            out_err   <= err_s;
            if (ok_inc_s && (frames_ok != 16'hFFFF)) begin
                frames_ok <= frames_ok + 16'd1;
            end else begin
                frames_ok <= frames_ok;
            end
            if (bad_inc_s && (frames_bad != 16'hFFFF)) begin
                frames_bad <= frames_bad + 16'd1;
            end else begin
                frames_bad <= frames_bad;
            end
        end
    end

endmodule

// File: tb/tb_eth_vlg_rx_fcs_strip.sv
// Directed + randomized bench for eth_vlg_rx_fcs_strip against a frame-level
// reference model (payload CRC compared with the transmitted FCS).
module tb_eth_vlg_rx_fcs_strip;

    localparam int PRE_MIN = 5;
    localparam int PRE_MAX = 15;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1518;

    logic        clk_rx = 1'b0;
    logic        rst_rx_n;
    logic        in_val;
    logic [7:0]  in_dat;
    logic [7:0]  out_dat;
    logic        out_val, out_sof, out_eof, out_err;
    logic [15:0] frames_ok, frames_bad;

    eth_vlg_rx_fcs_strip #(
        .PRE_MIN(PRE_MIN), .PRE_MAX(PRE_MAX), .MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)
    ) dut (
        .clk_rx(clk_rx), .rst_rx_n(rst_rx_n), .in_val(in_val), .in_dat(in_dat),
        .out_dat(out_dat), .out_val(out_val), .out_sof(out_sof), .out_eof(out_eof),
        .out_err(out_err), .frames_ok(frames_ok), .frames_bad(frames_bad)
    );

    always #5 clk_rx = ~clk_rx;

    int cyc = 0;
    always @(posedge clk_rx) cyc <= cyc + 1;

    logic [7:0]  tx_q[$];
    logic [10:0] exp_q[$];
    logic [10:0] mon_q[$];
    int          mon_cyc_q[$];
    int          exp_ok = 0, exp_bad = 0;
    int          stray = 0;
    int          n_chk = 0, n_pass = 0;
    int          sfd_cyc;

    // Output monitor: {sof, eof, err (only kept with eof), dat}
    always @(negedge clk_rx) begin
        if (out_val) begin
            mon_q.push_back({out_sof, out_eof, out_err & out_eof, out_dat});
            mon_cyc_q.push_back(cyc);
        end else if (out_sof || out_eof) begin
            stray++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] crc_of(input int start, input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, tx_q[start + i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Builds preamble, SFD, payload and FCS; optional bit flip and tail truncation
    task automatic build_frame(input int pre_n, input int pay_len, input bit rnd,
                               input int flip_idx, input int trunc);
        int start;
        logic [31:0] fcs;
        tx_q.delete();
        for (int i = 0; i < pre_n; i++) tx_q.push_back(8'h55);
        tx_q.push_back(8'hD5);
        start = tx_q.size();
        for (int i = 0; i < pay_len; i++) tx_q.push_back(rnd ? 8'($urandom) : 8'(i));
        fcs = crc_of(start, pay_len);
        for (int i = 0; i < 4; i++) tx_q.push_back(fcs[8*i +: 8]);
        if (flip_idx >= 0) tx_q[start + flip_idx] = tx_q[start + flip_idx] ^ 8'h01;
        for (int i = 0; i < trunc; i++) void'(tx_q.pop_back());
    endtask

    // Reference model: interpret the whole frame at once
    function automatic void model();
        int n, start, len;
        logic [31:0] fcs_rx;
        bit err;
        n = 0;
        while (n < tx_q.size() && tx_q[n] == 8'h55) n++;
        if (n == 0 || n > PRE_MAX || n == tx_q.size() || tx_q[n] != 8'hD5 || n < PRE_MIN) begin
            exp_bad++;
            return;
        end
        start = n + 1;
        len = tx_q.size() - start;
        if (len <= 4) begin
            exp_bad++;
            return;
        end
        fcs_rx = {tx_q[start+len-1], tx_q[start+len-2], tx_q[start+len-3], tx_q[start+len-4]};
        err = (fcs_rx != crc_of(start, len - 4)) || (len < MIN_LEN) || (len > MAX_LEN);
        for (int k = 0; k < len - 4; k++)
            exp_q.push_back({k == 0, k == len - 5, (k == len - 5) && err, tx_q[start + k]});
        if (err) exp_bad++;
        else exp_ok++;
    endfunction

    task automatic send();
        sfd_cyc = -1;
        for (int i = 0; i < tx_q.size(); i++) begin
            @(posedge clk_rx); #1;
            in_val = 1'b1;
            in_dat = tx_q[i];
            if (sfd_cyc < 0 && tx_q[i] == 8'hD5) sfd_cyc = cyc + 1;
        end
        @(posedge clk_rx); #1;
        in_val = 1'b0;
        in_dat = 8'h00;
        model();
    endtask

    task automatic check_frames(input string tag);
        repeat (3) @(posedge clk_rx);
        @(negedge clk_rx); #1;
        chk({tag, " count"}, mon_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
            chk({tag, " byte"}, 32'(mon_q[i]), 32'(exp_q[i]));
            if (i > 0 && !exp_q[i-1][9]) chk({tag, " gapless"}, mon_cyc_q[i] - mon_cyc_q[i-1], 1);
        end
        chk({tag, " frames_ok"}, 32'(frames_ok), exp_ok);
        chk({tag, " frames_bad"}, 32'(frames_bad), exp_bad);
        mon_q.delete();
        mon_cyc_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst_rx_n = 1'b0;
        in_val   = 1'b0;
        in_dat   = 8'h00;
        repeat (3) @(posedge clk_rx);
        #1;
        chk("rst out_val", 32'(out_val), 0);
        chk("rst out_sof", 32'(out_sof), 0);
        chk("rst out_eof", 32'(out_eof), 0);
        chk("rst out_err", 32'(out_err), 0);
        chk("rst out_dat", 32'(out_dat), 0);
        chk("rst frames_ok", 32'(frames_ok), 0);
        chk("rst frames_bad", 32'(frames_bad), 0);
        @(posedge clk_rx); #1;
        rst_rx_n = 1'b1;

        build_frame(7, 60, 1'b0, -1, 0);
        send();
        repeat (3) @(posedge clk_rx);
        @(negedge clk_rx); #1;
        chk("latency", mon_cyc_q[0] - sfd_cyc, 6);
        check_frames("good");

        build_frame(7, 60, 1'b0, 10, 0);
        send();
        check_frames("bitflip");

        build_frame(7, 36, 1'b1, -1, 0);
        send();
        check_frames("runt");

        tx_q.delete();
        for (int i = 0; i < 3; i++) tx_q.push_back(8'h55);
        tx_q.push_back(8'h12);
        for (int i = 0; i < 70; i++) tx_q.push_back(8'($urandom));
        send();
        build_frame(7, 60, 1'b1, -1, 0);
        send();
        check_frames("badpre");

        build_frame(7, 60, 1'b1, -1, 0);
        send();
        build_frame(7, 60, 1'b1, -1, 0);
        send();
        check_frames("b2b");

        build_frame(PRE_MIN - 1, 60, 1'b1, -1, 0);
        send();
        build_frame(PRE_MIN, 60, 1'b1, -1, 0);
        send();
        build_frame(PRE_MAX, 60, 1'b1, -1, 0);
        send();
        build_frame(PRE_MAX + 1, 60, 1'b1, -1, 0);
        send();
        check_frames("prelim");

        build_frame(7, 1, 1'b1, -1, 0);
        send();
        build_frame(7, 3, 1'b1, -1, 4);
        send();
        build_frame(7, 59, 1'b1, -1, 0);
        send();
        check_frames("short");

        build_frame(7, 1514, 1'b1, -1, 0);
        send();
        build_frame(7, 1515, 1'b1, -1, 0);
        send();
        check_frames("oversize");

        for (int f = 0; f < 12; f++) begin
            int pl, flip, trunc;
            pl    = $urandom_range(0, 100);
            flip  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, pl + 3) : -1;
            trunc = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0;
            build_frame($urandom_range(3, 16), pl, 1'b1, flip, trunc);
            send();
            check_frames("random");
        end

        build_frame(7, 60, 1'b1, -1, 0);
        for (int i = 0; i <= 7 + 1 + 20; i++) begin
            @(posedge clk_rx); #1;
            in_val = 1'b1;
            in_dat = tx_q[i];
        end
        #2;
        rst_rx_n = 1'b0;
        #1;
        chk("midrst out_val", 32'(out_val), 0);
        chk("midrst out_dat", 32'(out_dat), 0);
        chk("midrst frames_ok", 32'(frames_ok), 0);
        chk("midrst frames_bad", 32'(frames_bad), 0);
        in_val = 1'b0;
        in_dat = 8'h00;
        mon_q.delete();
        mon_cyc_q.delete();
        exp_q.delete();
        exp_ok = 0;
        exp_bad = 0;
        repeat (2) @(posedge clk_rx);
        #1;
        rst_rx_n = 1'b1;
        build_frame(7, 60, 1'b1, -1, 0);
        send();
        check_frames("postrst");

        chk("stray markers", stray, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/eth_vlg_rx_fcs_strip.md
# eth_vlg_rx_fcs_strip

Receive-side framing stage that consumes the raw byte stream driven on a `phy` output (`val`/`dat`, preamble, SFD and FCS included) by the device model or PHY adapter. It strips preamble/SFD, checks CRC-32 and length, and removes the 4 FCS bytes. Payload bytes (destination MAC through last data byte) are forwarded with start, end and error markers to the MAC parser. Per-frame good and bad counts are kept for the bench and for status.

## Interface
Parameters:
- `PRE_MIN`, 5: minimum count of 0x55 bytes before SFD.
- `PRE_MAX`, 15: maximum count of 0x55 bytes before SFD.
- `MIN_LEN`, 64: minimum frame length in bytes after SFD, FCS included.
- `MAX_LEN`, 1518: maximum frame length in bytes after SFD, FCS included.

Ports:
- `clk_rx` in 1: single clock for the block.
- `rst_rx_n` in 1: reset, asynchronous, active-low.
- `in_val` in 1: byte valid; high and contiguous for one whole frame.
- `in_dat` in 8: input byte.
- `out_dat` out 8: payload byte.
- `out_val` out 1: `out_dat` valid.
- `out_sof` out 1: marks the first payload byte; only with `out_val`.
- `out_eof` out 1: marks the last payload byte; only with `out_val`.
- `out_err` out 1: frame bad; meaningful only with `out_eof`.
- `frames_ok` out 16: count of good frames, saturating.
- `frames_bad` out 16: count of bad or dropped frames, saturating.

## Operation
- States and transitions:
  - IDLE: `in_val`=1 and 0x55 → PRE, with `pre_cnt`=1. `in_val`=1 and any other byte → DROP.
  - PRE, byte 0x55: `pre_cnt`++. If `pre_cnt` would exceed `PRE_MAX` → DROP.
  - PRE, byte 0xD5: if `pre_cnt`≥`PRE_MIN` → DATA; otherwise → DROP.
  - PRE, any other byte → DROP.
  - PRE, `in_val`=0 → IDLE and `frames_bad`++.
  - DATA: each byte goes through the CRC and a 5-byte shift register; `len`++ (16-bit, saturates at 0xFFFF).
  - DATA, `in_val`=0 → IDLE; end-of-frame is processed on that same cycle.
  - DROP: no output. When `in_val`=0 → IDLE and `frames_bad`++.
- CRC:
  - Reflected CRC-32, polynomial 0xEDB88320, initialised to 0xFFFFFFFF on SFD.
  - Runs over every byte after SFD, FCS included, LSB first.
  - Frame is good iff the final register equals residue 0xDEBB20E3.
- Forwarding:
  - Byte k after SFD (k from 0) is emitted once byte k+5 is sampled.
  - Bytes still in the shift register when `in_val` falls: the oldest (byte `len`−5) is emitted with `out_eof`=1. The remaining 4 (the FCS) are discarded.
  - `out_sof`=1 on the first emitted byte of each frame.
  - When `len`=5, the single payload byte carries both `out_sof` and `out_eof`.
  - When `len`≤4, nothing is emitted and `frames_bad`++.
- `out_err` = CRC bad OR `len`<`MIN_LEN` OR `len`>`MAX_LEN`.
  - On end-of-frame: `frames_ok`++ if `out_err`=0, otherwise `frames_bad`++.
  - Oversize frames are still forwarded in full; only flagged.
- Counters hold at 0xFFFF; they are never cleared except by reset.

## Timing
- All outputs are registered. On reset, every output is 0, the FSM is in IDLE, and the shift register, `len` and `pre_cnt` are cleared.
- Reset assertion takes effect immediately, mid-frame included. The interrupted frame is not counted and no `out_eof` is produced.
- After reset release with `in_val` already high: the frame is parsed from the current byte. A non-0x55 byte → DROP.
- Latency:
  - `out_val` for byte k rises on the edge that samples byte k+5.
  - The `out_eof` byte appears on the edge that first samples `in_val`=0.
  - `out_val` is a gapless run of (`len`−4) cycles, ending on the eof cycle.
- Counters update on the same edge as the `out_eof` or drop decision.
- Minimum inter-frame gap is 1 cycle with `in_val`=0.
  - A byte with `in_val`=1 in the cycle after end-of-frame processing is taken as the first preamble byte.
  - The eof output of the previous frame and the start of the next frame's preamble may coincide; there is no interaction between them.
- No backpressure; the downstream stage must accept 1 byte/cycle.

## Test plan
- Good frame: 7×0x55, 0xD5, 60 bytes 0x00..0x3B, valid FCS.
  - Expect 60 `out_val` cycles with data 0x00..0x3B, `out_sof` on 0x00, `out_eof` on 0x3B, `out_err`=0, `frames_ok`=1.
  - First `out_val` occurs 6 cycles after SFD is sampled.
- Same frame with payload byte 10 bit-flipped.
  - Expect identical framing, `out_err`=1 at eof, `frames_bad`=1, `frames_ok`=0.
- Runt: 36-byte payload, correct FCS (`len`=40).
  - Expect 36 bytes out, `out_err`=1, `frames_bad`=1.
- Bad preamble: 3×0x55, 0x12, 70 bytes, then a 1-cycle gap, then a good frame.
  - First frame: no `out_val`, `frames_bad`=1.
  - Second frame: forwarded, `frames_ok`=1.
- Back-to-back: two good 64-byte frames with a 1-cycle gap.
  - Expect two clean sof..eof runs and `frames_ok`=2.
- Reset: assert `rst_rx_n`=0 at payload byte 20.
  - Outputs drop to 0 immediately and counters are 0.
  - A good frame sent after release yields `frames_ok`=1.
